// File: rtl/store_write_ctrl_pkg.sv
// Shared encodings for the store write sequencer.
// Store sizes, FSM states and the latched request bundle.
package store_write_ctrl_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] bdata;
  } store_req_t;

  function automatic logic req_bad(
    input logic [1:0] size,
    input logic [1:0] ofs
  );
    return (size == SZ_RSVD)
        || (size == SZ_WORD && ofs != 2'b00)
        || (size == SZ_HALF && ofs[0]);
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Replaces one little-endian lane of a memory word
// with the low bits of the store operand.
module store_lane_merge
  import store_write_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] bdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  output logic [31:0] merged
);

  always_comb begin
    merged = rdata;
    unique case (1'b1)
      (size == SZ_WORD):
        merged = bdata;
      (size == SZ_HALF && !addr[1]):
        merged[15:0] = bdata[15:0];
      (size == SZ_HALF && addr[1]):
        merged[31:16] = bdata[15:0];
      (size == SZ_BYTE):
        merged[{addr, 3'b000} +: 8] = bdata[7:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/store_write_ctrl.sv
// Multicycle store sequencer: sw writes B directly,
// sh/sb read-merge-write the aligned word.
module store_write_ctrl
  import store_write_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] b_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] storesize_out,
  output logic        memwritecontrol,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t           state_q;
  state_t           state_d;
  store_req_t       req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      ss_q;
  logic             mwc_q;
  logic [31:0]      merged;
  logic             rd_last;

  store_lane_merge u_merge (
    .rdata  (mem_rdata),
    .bdata  (req_q.bdata),
    .size   (req_q.size),
    .addr   (req_q.addr[1:0]),
    .merged (merged)
  );

  assign rd_last = (state_q == S_WAIT)
                && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_bad(store_size, addr[1:0]))
            state_d = S_ERR;
          else if (store_size == SZ_WORD)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  if (rd_last) state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The merged word is captured on the read-data
  // cycle so it is already stable during WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      ss_q    <= '0;
      mwc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        req_q <= '{addr:  addr,
                   size:  store_size,
                   bdata: b_data};
      end
      if (state_q == S_READ)
        cnt_q <= CNT_W'(MEM_LATENCY);
      else if (state_q == S_WAIT)
        cnt_q <= cnt_q - CNT_W'(1);
      if (rd_last) begin
        ss_q  <= merged;
        mwc_q <= 1'b0;
      end
      if (state_q == S_IDLE
          && state_d == S_WRITE)
        mwc_q <= 1'b1;
    end
  end

  assign mem_addr        = {req_q.addr[31:2], 2'b00};
  assign mem_wr          = (state_q == S_WRITE);
  assign storesize_out   = ss_q;
  assign memwritecontrol = mwc_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE)
                        || (state_q == S_ERR);
  assign err             = (state_q == S_ERR);

endmodule

// File: tb/tb_store_write_ctrl.sv
// Bench for store_write_ctrl at latencies 1 and 3,
// directed cases followed by randomized stores.
module tb_store_write_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [1:0]  store_size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] b_data = '0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem_addr1, mem_addr3;
  logic [31:0] ss1, ss3;
  logic        mem_wr1, mem_wr3;
  logic        mwc1, mwc3;
  logic        busy1, busy3;
  logic        done1, done3;
  logic        err1, err3;

  int          vectors = 0;
  int          miscompares = 0;
  int          sel = 0;
  logic [31:0] last_ss [2];
  logic        last_mwc [2];

  logic [31:0] o_addr, o_ss;
  logic        o_wr, o_mwc, o_busy, o_done, o_err;

  store_write_ctrl #(.MEM_LATENCY(1)) dut1 (
    .clk             (clk),
    .reset           (reset),
    .start           (start1),
    .store_size      (store_size),
    .addr            (addr),
    .b_data          (b_data),
    .mem_rdata       (mem_rdata),
    .mem_addr        (mem_addr1),
    .mem_wr          (mem_wr1),
    .storesize_out   (ss1),
    .memwritecontrol (mwc1),
    .busy            (busy1),
    .done            (done1),
    .err             (err1)
  );

  store_write_ctrl #(.MEM_LATENCY(3)) dut3 (
    .clk             (clk),
    .reset           (reset),
    .start           (start3),
    .store_size      (store_size),
    .addr            (addr),
    .b_data          (b_data),
    .mem_rdata       (mem_rdata),
    .mem_addr        (mem_addr3),
    .mem_wr          (mem_wr3),
    .storesize_out   (ss3),
    .memwritecontrol (mwc3),
    .busy            (busy3),
    .done            (done3),
    .err             (err3)
  );

  always #5 clk = ~clk;

  always_comb begin
    o_addr = (sel != 0) ? mem_addr3 : mem_addr1;
    o_ss   = (sel != 0) ? ss3 : ss1;
    o_wr   = (sel != 0) ? mem_wr3 : mem_wr1;
    o_mwc  = (sel != 0) ? mwc3 : mwc1;
    o_busy = (sel != 0) ? busy3 : busy1;
    o_done = (sel != 0) ? done3 : done1;
    o_err  = (sel != 0) ? err3 : err1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mem_addr"}, o_addr, 32'h0);
    chk({tag, " storesize_out"}, o_ss, 32'h0);
    chk({tag, " mem_wr"}, {31'h0, o_wr}, 32'h0);
    chk({tag, " mwc"}, {31'h0, o_mwc}, 32'h0);
    chk({tag, " busy"}, {31'h0, o_busy}, 32'h0);
    chk({tag, " done"}, {31'h0, o_done}, 32'h0);
    chk({tag, " err"}, {31'h0, o_err}, 32'h0);
  endtask

  // Byte-array view of the word: drop the store lane in place.
  function automatic logic [31:0] ref_merge(
    input logic [1:0]  sz,
    input logic [31:0] a,
    input logic [31:0] r,
    input logic [31:0] b
  );
    logic [7:0] by [4];
    int base;
    for (int i = 0; i < 4; i++) by[i] = r[8*i +: 8];
    if (sz == 2'b10) begin
      by[a[1:0]] = b[7:0];
    end else begin
      base = a[1] ? 2 : 0;
      by[base]     = b[7:0];
      by[base + 1] = b[15:8];
    end
    return {by[3], by[2], by[1], by[0]};
  endfunction

  task automatic run_op(input int d,
                        input logic [1:0]  sz,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] rd);
    int L, dn, wr, hold;
    logic bad, xm;
    logic [31:0] xs, al;
    sel = d;
    L = (d != 0) ? 3 : 1;
    bad = (sz == 2'b11)
       || (sz == 2'b00 && a[1:0] != 2'b00)
       || (sz == 2'b01 && a[0]);
    dn = bad ? 1 : (sz == 2'b00) ? 2 : L + 3;
    wr = bad ? -1 : dn - 1;
    hold = bad ? 1 : 2;
    xs = (bad || sz == 2'b00) ? last_ss[d]
                              : ref_merge(sz, a, rd, b);
    xm = bad ? last_mwc[d] : (sz == 2'b00);
    al = {a[31:2], 2'b00};
    addr = a;
    b_data = b;
    store_size = sz;
    mem_rdata = $urandom;
    if (d != 0) start3 = 1'b1;
    else start1 = 1'b1;
    for (int k = 1; k <= L + 6; k++) begin
      @(posedge clk);
      #1;
      chk("mem_wr", {31'h0, o_wr}, {31'h0, k == wr});
      chk("done", {31'h0, o_done}, {31'h0, k == dn});
      chk("err", {31'h0, o_err},
          {31'h0, bad && k == dn});
      chk("busy", {31'h0, o_busy}, {31'h0, k <= dn});
      if (!bad && k <= wr)
        chk("mem_addr", o_addr, al);
      if (k == wr || k == dn) begin
        chk("storesize_out", o_ss, xs);
        chk("memwritecontrol", {31'h0, o_mwc},
            {31'h0, xm});
      end
      if (k == 1) begin
        addr = $urandom;
        b_data = $urandom;
        store_size = 2'($urandom);
      end
      if (k == hold) begin
        start1 = 1'b0;
        start3 = 1'b0;
      end
      if (k < L) mem_rdata = $urandom;
      else if (k == L) mem_rdata = rd;
    end
    last_ss[d] = xs;
    last_mwc[d] = xm;
  endtask

  initial begin
    logic [1:0]  rsz;
    logic [31:0] ra;
    last_ss[0] = '0;
    last_ss[1] = '0;
    last_mwc[0] = 1'b0;
    last_mwc[1] = 1'b0;

    #12;
    sel = 0; #1; chk_zero("reset d1");
    sel = 1; #1; chk_zero("reset d3");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0);
    run_op(0, 2'b10, 32'h103, 32'hAB, 32'h11223344);
    run_op(0, 2'b01, 32'h102, 32'hCAFE, 32'h11223344);
    run_op(0, 2'b01, 32'h100, 32'hCAFE, 32'h11223344);
    run_op(0, 2'b01, 32'h101, 32'h1234, 32'h0);
    run_op(0, 2'b00, 32'h102, 32'h5678, 32'h0);
    run_op(0, 2'b11, 32'h104, 32'h9ABC, 32'h0);
    run_op(1, 2'b10, 32'h0, 32'h5A, 32'hA1B2C3D4);
    run_op(1, 2'b00, 32'h200, 32'h0BADF00D, 32'h0);
    run_op(1, 2'b11, 32'h200, 32'h1, 32'h0);

    // Abort a latency-3 byte store in WAIT.
    sel = 1;
    addr = 32'h40;
    b_data = 32'h77;
    store_size = 2'b10;
    mem_rdata = 32'h01020304;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-abort busy", {31'h0, o_busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk_zero("abort");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("post-abort mem_wr", {31'h0, o_wr}, 32'h0);
      chk("post-abort done", {31'h0, o_done}, 32'h0);
    end
    last_ss[0] = '0;
    last_ss[1] = '0;
    last_mwc[0] = 1'b0;
    last_mwc[1] = 1'b0;

    for (int n = 0; n < 40; n++) begin
      rsz = 2'($urandom);
      ra = $urandom;
      if ($urandom_range(0, 1) != 0) begin
        if (rsz == 2'b00) ra[1:0] = 2'b00;
        if (rsz == 2'b01) ra[0] = 1'b0;
      end
      run_op(int'($urandom_range(0, 1)), rsz, ra,
             $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
